// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_controller
// Description : Run sequencer for the single-cycle MIPS sort CPU on BASYS3.
//               Debounces the sort (centre) and display (left) buttons, holds
//               the CPU in reset until a sort is requested, issues clk_enable
//               step strobes while the program runs, ends the run on halt or
//               watchdog timeout, then scans data-memory word indices out to
//               the 7-segment display path on request.
// Ports       : clk, reset                 - clock, synchronous active-high reset
//               center_button_enable_sort  - raw sort button (asynchronous)
//               left_button_display_data   - raw display button (asynchronous)
//               instruction_counter        - CPU PC, observation only
//               cpu_halt                   - datapath reached halt
//               clk_enable                 - one-cycle CPU step strobe
//               cpu_reset                  - holds CPU in reset
//               finished_sort, timeout     - run complete / ended by watchdog
//               disp_addr, disp_valid      - word index shown on the display
//               state                      - IDLE=0 RUN=1 DONE=2 SHOW=3
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_controller #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   STEP_DIV        = 4,
    parameter int   PC_W            = 8,
    parameter int   MAX_STEPS       = 255,
    parameter int   NUM_WORDS       = 8,
    parameter int   DISP_HOLD       = 16,
    localparam int  AW              = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            center_button_enable_sort,
    input  logic            left_button_display_data,
    input  logic [PC_W-1:0] instruction_counter,
    input  logic            cpu_halt,
    output logic            clk_enable,
    output logic            cpu_reset,
    output logic            finished_sort,
    output logic            timeout,
    output logic [AW-1:0]   disp_addr,
    output logic            disp_valid,
    output logic [1:0]      state
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_DIV_W  = $clog2(STEP_DIV);
    localparam int c_STEP_W = $clog2(MAX_STEPS + 1);
    localparam int c_HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(STEP_DIV - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_MAX  = c_STEP_W'(MAX_STEPS);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(MAX_STEPS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(DISP_HOLD - 1);
    localparam logic [AW-1:0]       c_ADDR_LAST = AW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = sort, bit 1 = display
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_press;

    assign w_raw = {left_button_display_data, center_button_enable_sort};

    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        logic              r_s0;
        logic              r_s1;
        logic              r_lvl;
        logic              r_lvl_d;
        logic              r_pulse;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s0    <= 1'b0;
                r_s1    <= 1'b0;
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
                r_pulse <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s0    <= w_raw[gi];
                r_s1    <= r_s0;
                r_lvl_d <= r_lvl;
                // Registered edge pulse keeps the press strobe glitch-free
                r_pulse <= r_lvl & ~r_lvl_d;
                // Any sample agreeing with the current level restarts the run
                // of differing samples, so bounces never accumulate.
                if (r_s1 != r_lvl) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_lvl <= r_s1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_press[gi] = r_pulse;
    end

    logic w_sort_press;
    logic w_disp_press;

    // Sort has priority; a coincident display press is dropped
    assign w_sort_press = w_press[0];
    assign w_disp_press = w_press[1] & ~w_press[0];

    // PC is exported for observation by the board top only
    logic w_unused_pc;
    assign w_unused_pc = ^instruction_counter;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t              r_state,   w_state_nx;
    logic [c_DIV_W-1:0]  r_div,     w_div_nx;
    logic [c_STEP_W-1:0] r_steps,   w_steps_nx;
    logic                r_timeout, w_timeout_nx;
    logic [AW-1:0]       r_addr,    w_addr_nx;
    logic [c_HOLD_W-1:0] r_hold,    w_hold_nx;
    logic                r_restart, w_restart_nx;  // sort pressed in RUN: re-enter RUN after one IDLE cycle
    logic                w_clk_en;

    assign w_clk_en = (r_state == S_RUN) && (r_div == c_DIV_LAST) && !cpu_halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_steps   <= '0;
            r_timeout <= 1'b0;
            r_addr    <= '0;
            r_hold    <= '0;
            r_restart <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_div     <= w_div_nx;
            r_steps   <= w_steps_nx;
            r_timeout <= w_timeout_nx;
            r_addr    <= w_addr_nx;
            r_hold    <= w_hold_nx;
            r_restart <= w_restart_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_div_nx     = r_div;
        w_steps_nx   = r_steps;
        w_timeout_nx = r_timeout;
        w_addr_nx    = r_addr;
        w_hold_nx    = r_hold;
        w_restart_nx = r_restart;

        case (r_state)
            S_IDLE: begin
                if (w_sort_press || r_restart) begin
                    w_state_nx   = S_RUN;
                    w_div_nx     = '0;
                    w_steps_nx   = '0;
                    w_timeout_nx = 1'b0;
                    w_restart_nx = 1'b0;
                end
            end
            S_RUN: begin
                if (w_sort_press) begin
                    w_state_nx   = S_IDLE;
                    w_restart_nx = 1'b1;
                end else if (cpu_halt) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_div_nx = (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
                    if (w_clk_en) begin
                        // The pulse that brings the count to MAX_STEPS is the last one
                        if (r_steps >= c_STEP_LAST) begin
                            w_steps_nx   = c_STEP_MAX;
                            w_state_nx   = S_DONE;
                            w_timeout_nx = 1'b1;
                        end else begin
                            w_steps_nx = r_steps + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (w_sort_press) begin
                    w_state_nx = S_IDLE;
                end else if (w_disp_press) begin
                    w_state_nx = S_SHOW;
                    w_addr_nx  = '0;
                    w_hold_nx  = '0;
                end
            end
            S_SHOW: begin
                if (w_sort_press) begin
                    w_state_nx = S_IDLE;
                    w_addr_nx  = '0;
                    w_hold_nx  = '0;
                end else if (w_disp_press) begin
                    w_state_nx = S_DONE;
                    w_addr_nx  = '0;
                    w_hold_nx  = '0;
                end else if (r_hold == c_HOLD_LAST) begin
                    w_hold_nx = '0;
                    if (r_addr == c_ADDR_LAST) begin
                        w_state_nx = S_DONE;
                        w_addr_nx  = '0;
                    end else begin
                        w_addr_nx = r_addr + 1'b1;
                    end
                end else begin
                    w_hold_nx = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign clk_enable    = w_clk_en;
    assign cpu_reset     = (r_state == S_IDLE);
    assign finished_sort = (r_state == S_DONE) || (r_state == S_SHOW);
    assign timeout       = r_timeout;
    assign disp_addr     = r_addr;
    assign disp_valid    = (r_state == S_SHOW);
    assign state         = r_state;

endmodule
`default_nettype wire
